// File: rtl/simple_pkg.sv
`default_nettype none
// ============================================================================
// Module      : simple_pkg
// Description : Shared fetch/decode definitions: fetch FSM state encoding,
//               COMMAND-word field positions and the HLT opcode constants.
// Revision    : 1.0 - initial release
// ============================================================================
package simple_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        ISSUE = 3'd3,
        HALT  = 3'd4
    } fetch_state_t;

    localparam logic [1:0] OPC_ALU = 2'b11;
    localparam logic [3:0] OP3_HLT = 4'b1111;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 14;
    localparam int OP3_MSB = 7;
    localparam int OP3_LSB = 4;

    // HLT is the ALU-class opcode with the all-ones secondary opcode
    function automatic logic is_hlt(input logic [15:0] word);
        return (word[OPC_MSB:OPC_LSB] == OPC_ALU) &&
               (word[OP3_MSB:OP3_LSB] == OP3_HLT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : fetch_watchdog
// Description : Counts cycles spent waiting for instruction memory and flags
//               expiry on the TIMEOUT-th waiting cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_watchdog #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_count_en,
    output logic o_expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_count;

    // Cleared while the request is issued so each wait starts from zero
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_count_en && !o_expired) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_expired = i_count_en && (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch front end. Holds the PC, issues one-word
//               reads, registers the returned COMMAND word and hands it to
//               decode with valid/ready. Redirects on taken branch, stops on
//               HLT. Optional macro FETCH_TIMEOUT_EN adds a WAIT watchdog
//               that re-issues the request and sets sticky fetch_err.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import simple_pkg::*;
#(
    parameter int               ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int               TIMEOUT  = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_rvalid,
    output logic [15:0]       cmd,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_target,
    output logic [ADDR_W-1:0] pc_plus1,
    output logic              halted,
    output logic              fetch_err
);

    fetch_state_t      r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [15:0]       r_cmd;
    logic              r_cmd_valid;
    logic              r_halted;
    logic              r_fetch_err;
    logic              w_timeout;
    logic [ADDR_W-1:0] w_pc_plus1;

    if (TIMEOUT < 1) begin : g_timeout_range
        $error("fetch_unit: TIMEOUT must be at least 1");
    end

`ifdef FETCH_TIMEOUT_EN
    fetch_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (r_state == REQ),
        .i_count_en (r_state == WAIT),
        .o_expired  (w_timeout)
    );
`else
    assign w_timeout = 1'b0;
`endif

    // Wraps naturally modulo 2^ADDR_W
    assign w_pc_plus1 = r_pc + ADDR_W'(1);

    // Fetch sequencer: request, wait for memory, hold word until accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_pc        <= RESET_PC;
            r_cmd       <= 16'h0000;
            r_cmd_valid <= 1'b0;
            r_halted    <= 1'b0;
            r_fetch_err <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (run) begin
                        r_state <= REQ;
                    end
                end
                REQ: begin
                    r_state <= WAIT;
                end
                WAIT: begin
                    // A word arriving together with expiry is still taken
                    if (mem_rvalid) begin
                        r_cmd       <= mem_rdata;
                        r_cmd_valid <= 1'b1;
                        r_state     <= ISSUE;
                    end else if (w_timeout) begin
                        r_fetch_err <= 1'b1;
                        r_state     <= REQ;
                    end
                end
                ISSUE: begin
                    if (cmd_ready) begin
                        r_cmd_valid <= 1'b0;
                        if (is_hlt(r_cmd)) begin
                            r_halted <= 1'b1;
                            r_state  <= HALT;
                        end else begin
                            r_pc    <= pc_load ? pc_target : w_pc_plus1;
                            r_state <= REQ;
                        end
                    end
                end
                HALT: begin
                    r_state <= HALT;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign mem_rd    = (r_state == REQ);
    assign mem_addr  = r_pc;
    assign cmd       = r_cmd;
    assign cmd_valid = r_cmd_valid;
    assign pc_plus1  = w_pc_plus1;
    assign halted    = r_halted;
    assign fetch_err = r_fetch_err;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit. A memory responder
//               answers requests one cycle later; expected addresses and
//               COMMAND words are queued and compared as the DUT produces
//               them. A second instance with RESET_PC=16'hFFFF covers the
//               PC wrap (and the watchdog when FETCH_TIMEOUT_EN is defined).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam int TB_TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst, run, mem_rd, mem_rvalid, cmd_valid, cmd_ready, pc_load;
    logic        halted, fetch_err;
    logic [15:0] mem_addr, mem_rdata, cmd, pc_target, pc_plus1;

    logic        wr_rst, wr_run, wr_mem_rd, wr_rvalid, wr_cmd_valid, wr_ready;
    logic        wr_pc_load, wr_halted, wr_fetch_err;
    logic [15:0] wr_mem_addr, wr_rdata, wr_cmd, wr_pc_target, wr_pc_plus1;

    int          n_cmp = 0;
    int          n_mis = 0;
    int          n_acc = 0;
    int          cyc = 0;
    int          last_acc = 0;
    bit          chk_rate = 1'b0;
    bit          mem_en = 1'b1;
    bit          pend = 1'b0;
    logic [15:0] pend_addr = '0;
    logic [15:0] halt_addr = 16'h0012;
    logic [15:0] exp_addr_q[$];
    logic [15:0] exp_cmd_q[$];

    always #5 clk = ~clk;

    fetch_unit #(.ADDR_W(16), .RESET_PC(16'h0000), .TIMEOUT(TB_TIMEOUT)) dut (
        .clk(clk), .rst(rst), .run(run), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .cmd(cmd),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .pc_load(pc_load),
        .pc_target(pc_target), .pc_plus1(pc_plus1), .halted(halted),
        .fetch_err(fetch_err)
    );

    fetch_unit #(.ADDR_W(16), .RESET_PC(16'hFFFF), .TIMEOUT(TB_TIMEOUT)) dut_wrap (
        .clk(clk), .rst(wr_rst), .run(wr_run), .mem_rd(wr_mem_rd),
        .mem_addr(wr_mem_addr), .mem_rdata(wr_rdata), .mem_rvalid(wr_rvalid),
        .cmd(wr_cmd), .cmd_valid(wr_cmd_valid), .cmd_ready(wr_ready),
        .pc_load(wr_pc_load), .pc_target(wr_pc_target), .pc_plus1(wr_pc_plus1),
        .halted(wr_halted), .fetch_err(wr_fetch_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return (a == halt_addr) ? 16'hC0F0 : 16'h4000 + a;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_acc(input int n);
        for (int i = 0; i < 100 && n_acc < n; i++) @(negedge clk);
        check("accept_count", n_acc, n);
    endtask

    task automatic wait_cmd_valid();
        for (int i = 0; i < 20 && !cmd_valid; i++) @(negedge clk);
        check("cmd_valid_wait", {31'b0, cmd_valid}, 32'd1);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory with one cycle of latency
    always @(posedge clk) begin
        #1;
        if (mem_en) begin
            mem_rvalid = pend;
            mem_rdata  = pend ? mem_word(pend_addr) : 16'h0000;
            pend       = mem_rd;
            pend_addr  = mem_addr;
        end
    end

    // Scoreboard: requests and accepted words against the expected queues
    always @(negedge clk) begin
        if (!rst && mem_rd) begin
            if (exp_addr_q.size() == 0) check("extra_rd", {31'b0, mem_rd}, 32'd0);
            else check("mem_addr", {16'b0, mem_addr}, {16'b0, exp_addr_q.pop_front()});
        end
        if (cmd_valid && cmd_ready) begin
            if (exp_cmd_q.size() == 0) check("extra_cmd", {31'b0, cmd_valid}, 32'd0);
            else check("cmd", {16'b0, cmd}, {16'b0, exp_cmd_q.pop_front()});
            if (chk_rate && n_acc > 0) check("accept_gap", cyc - last_acc, 32'd3);
            last_acc = cyc;
            n_acc++;
        end
    end

    initial begin
        int k;
        rst = 1'b1; run = 1'b0; cmd_ready = 1'b0; pc_load = 1'b0; pc_target = '0;
        mem_rvalid = 1'b0; mem_rdata = '0;
        wr_rst = 1'b1; wr_run = 1'b0; wr_rvalid = 1'b0; wr_rdata = '0;
        wr_ready = 1'b0; wr_pc_load = 1'b0; wr_pc_target = '0;
        repeat (3) step();

        check("rst_mem_rd",    {31'b0, mem_rd},    32'd0);
        check("rst_mem_addr",  {16'b0, mem_addr},  32'h0000);
        check("rst_cmd",       {16'b0, cmd},       32'h0000);
        check("rst_cmd_valid", {31'b0, cmd_valid}, 32'd0);
        check("rst_halted",    {31'b0, halted},    32'd0);
        check("rst_fetch_err", {31'b0, fetch_err}, 32'd0);

        // Sequential run, branch at PC=3, stall at 0x10, HLT at 0x12
        foreach (exp_addr_q[i]) exp_addr_q.delete(i);
        exp_addr_q = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0010, 16'h0011, 16'h0012};
        exp_cmd_q  = '{16'h4000, 16'h4001, 16'h4002, 16'h4003, 16'h4010, 16'h4011, 16'hC0F0};
        chk_rate = 1'b1;
        rst = 1'b0; run = 1'b1; cmd_ready = 1'b1;
        step();
        run = 1'b0;

        wait_acc(3);
        step();
        pc_load = 1'b1; pc_target = 16'h0010;
        wait_cmd_valid();
        check("pc_plus1_at_3", {16'b0, pc_plus1}, 32'h0004);

        wait_acc(4);
        step();
        pc_load = 1'b0; cmd_ready = 1'b0; chk_rate = 1'b0;
        wait_cmd_valid();
        for (int i = 0; i < 5; i++) begin
            check("stall_cmd",   {16'b0, cmd},       32'h4010);
            check("stall_valid", {31'b0, cmd_valid}, 32'd1);
            check("stall_rd",    {31'b0, mem_rd},    32'd0);
            @(negedge clk);
        end
        step();
        cmd_ready = 1'b1;

        wait_acc(7);
        step();
        check("halted",       {31'b0, halted},    32'd1);
        check("halt_cmd_vld", {31'b0, cmd_valid}, 32'd0);
        run = 1'b1; pc_target = 16'h0020;
        for (int i = 0; i < 20; i++) begin
            pc_load = i[0];
            step();
        end
        run = 1'b0; pc_load = 1'b0;
        check("halt_sticky",  {31'b0, halted},    32'd1);
        check("no_fetch_err", {31'b0, fetch_err}, 32'd0);

        // Reset while waiting for memory, then a stale rvalid in IDLE
        mem_en = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0; run = 1'b1;
        exp_addr_q.push_back(16'h0000);
        step();
        run = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 16'hBEEF;
        step();
        mem_rvalid = 1'b0;
        check("late_rv_valid", {31'b0, cmd_valid}, 32'd0);
        check("late_rv_cmd",   {16'b0, cmd},       32'h0000);
        step();
        check("idle_no_rd",    {31'b0, mem_rd},    32'd0);
        check("idle_valid",    {31'b0, cmd_valid}, 32'd0);
        check("addr_q_left",   exp_addr_q.size(),  32'd0);
        check("cmd_q_left",    exp_cmd_q.size(),   32'd0);

        // PC wrap from RESET_PC=16'hFFFF
        check("wr_rst_addr", {16'b0, wr_mem_addr}, 32'hFFFF);
        wr_rst = 1'b0; wr_run = 1'b1;
        step();
        wr_run = 1'b0;
        check("wr_req_rd",   {31'b0, wr_mem_rd},   32'd1);
        check("wr_req_addr", {16'b0, wr_mem_addr}, 32'hFFFF);
        step();
        wr_rvalid = 1'b1; wr_rdata = 16'h1234;
        step();
        wr_rvalid = 1'b0;
        check("wr_cmd",      {16'b0, wr_cmd},       32'h1234);
        check("wr_cmd_vld",  {31'b0, wr_cmd_valid}, 32'd1);
        check("wr_pc_plus1", {16'b0, wr_pc_plus1},  32'h0000);
        wr_ready = 1'b1;
        step();
        wr_ready = 1'b0;
        check("wr_next_rd",   {31'b0, wr_mem_rd},   32'd1);
        check("wr_next_addr", {16'b0, wr_mem_addr}, 32'h0000);

`ifdef FETCH_TIMEOUT_EN
        // No response: request re-issued after TB_TIMEOUT waiting cycles
        k = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (wr_mem_rd) begin
                k = i;
                break;
            end
        end
        check("retry_gap",  k, TB_TIMEOUT + 1);
        check("retry_addr", {16'b0, wr_mem_addr}, 32'h0000);
        check("fetch_err",  {31'b0, wr_fetch_err}, 32'd1);
        step();
        wr_rvalid = 1'b1; wr_rdata = 16'h5555;
        step();
        wr_rvalid = 1'b0;
        check("retry_cmd",     {16'b0, wr_cmd},       32'h5555);
        check("fetch_err_stk", {31'b0, wr_fetch_err}, 32'd1);
`else
        k = 0;
        check("wr_fetch_err", {31'b0, wr_fetch_err} + k, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
